// File: rtl/parc_dmemresp_queue.sv
// Multi-entry data-memory response queue for the PARCv2 M stage: extends
// subword loads at enqueue, buffers results while M/W stall, bypasses when empty.
module parc_dmemresp_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              enq_val,
    output logic              enq_rdy,
    input  logic [DATA_W-1:0] enq_data,
    input  logic [2:0]        enq_type,
    input  logic [1:0]        enq_offset,
    output logic              deq_val,
    input  logic              deq_rdy,
    output logic [DATA_W-1:0] deq_data,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Subword select always looks at the low 32 bits; wider words only matter for lw.
    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] data,
        input logic [2:0]        ld_type,
        input logic [1:0]        offset
    );
        logic [31:0]       low_v;
        logic [7:0]        byte_v;
        logic [15:0]       half_v;
        logic [DATA_W-1:0] result_v;
        low_v  = data[31:0];
        byte_v = low_v[{offset, 3'b000} +: 8];
        half_v = offset[1] ? low_v[31:16] : low_v[15:0];
        case (ld_type)
            3'd1:    result_v = {{(DATA_W-8){byte_v[7]}}, byte_v};
            3'd2:    result_v = {{(DATA_W-8){1'b0}}, byte_v};
            3'd3:    result_v = {{(DATA_W-16){half_v[15]}}, half_v};
            3'd4:    result_v = {{(DATA_W-16){1'b0}}, half_v};
            default: result_v = data;
        endcase
        return result_v;
    endfunction

    // Modulo increment so non-power-of-two depths wrap correctly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt_v;
        if (ptr == LAST_PTR) begin
            nxt_v = {PTR_W{1'b0}};
        end else begin
            nxt_v = ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return nxt_v;
    endfunction

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_r;

    logic [DATA_W-1:0] ext_data_s;
    logic [DATA_W-1:0] deq_data_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              empty_s;
    logic              enq_rdy_s;
    logic              deq_val_s;
    logic              enq_fire_s;
    logic              deq_fire_s;
    logic              wr_s;
    logic              rd_s;

    // Handshake, bypass/storage decision and next occupancy.
    always_comb begin
        ext_data_s = extend_load(enq_data, enq_type, enq_offset);
        empty_s    = (count_r == {CNT_W{1'b0}});
        enq_rdy_s  = !full_r && !reset;
        if (reset || flush) begin
            deq_val_s = 1'b0;
        end else if (empty_s) begin
            deq_val_s = enq_val;
        end else begin
            deq_val_s = 1'b1;
        end
        if (empty_s) begin
            deq_data_s = ext_data_s;
        end else begin
            deq_data_s = mem_r[head_r];
        end
        enq_fire_s = enq_val && enq_rdy_s;
        deq_fire_s = deq_val_s && deq_rdy;
        // An empty queue with a ready consumer hands the word straight through.
        wr_s = enq_fire_s && !flush && !(empty_s && deq_rdy);
        rd_s = deq_fire_s && !empty_s;
        if (flush) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (wr_s && !rd_s) begin
            count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (rd_s && !wr_s) begin
            count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointer, occupancy and full-flag state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            full_r  <= 1'b0;
        end else if (flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            full_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_CNT);
            if (rd_s) begin
                head_r <= next_ptr(head_r);
            end
            if (wr_s) begin
                tail_r <= next_ptr(tail_r);
            end
        end
    end

    // Entry storage holds already-extended words and is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[tail_r] <= ext_data_s;
        end
    end

    assign enq_rdy  = enq_rdy_s;
    assign deq_val  = deq_val_s;
    assign deq_data = deq_data_s;
    assign count    = count_r;
    assign full     = full_r;

endmodule

// File: tb/tb_parc_dmemresp_queue.sv
// Self-checking bench for parc_dmemresp_queue: directed plan steps plus random
// traffic compared against a queue-based reference model.
module tb_parc_dmemresp_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              enq_val;
    logic              enq_rdy;
    logic [DATA_W-1:0] enq_data;
    logic [2:0]        enq_type;
    logic [1:0]        enq_offset;
    logic              deq_val;
    logic              deq_rdy;
    logic [DATA_W-1:0] deq_data;
    logic [CNT_W-1:0]  count;
    logic              full;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_q[$];

    always #5 clk = ~clk;

    parc_dmemresp_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_data(enq_data),
        .enq_type(enq_type), .enq_offset(enq_offset),
        .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_data(deq_data),
        .count(count), .full(full)
    );

    // Reference extension by shifting, masking and arithmetic sign folding.
    function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [2:0] t, input logic [1:0] o);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * o)) & 32'h0000_00FF;
        h = (d >> (16 * o[1])) & 32'h0000_FFFF;
        case (t)
            3'd1:    return (b ^ 32'h0000_0080) - 32'h0000_0080;
            3'd2:    return b;
            3'd3:    return (h ^ 32'h0000_8000) - 32'h0000_8000;
            3'd4:    return h;
            default: return d;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [2:0] ty, input logic [1:0] off,
                         input logic [31:0] d, input logic dr, input logic fl);
        enq_val    = ev;
        enq_type   = ty;
        enq_offset = off;
        enq_data   = d;
        deq_rdy    = dr;
        flush      = fl;
    endtask

    task automatic check_model(input string tag);
        logic exp_val;
        logic exp_rdy;
        exp_rdy = !reset && (model_q.size() < DEPTH);
        if (reset || flush) exp_val = 1'b0;
        else if (model_q.size() == 0) exp_val = enq_val;
        else exp_val = 1'b1;
        chk({tag, "_deq_val"}, {31'd0, deq_val}, {31'd0, exp_val});
        chk({tag, "_enq_rdy"}, {31'd0, enq_rdy}, {31'd0, exp_rdy});
        chk({tag, "_count"}, {30'd0, count}, 32'(model_q.size()));
        chk({tag, "_full"}, {31'd0, full}, {31'd0, (model_q.size() == DEPTH)});
        if (exp_val) begin
            if (model_q.size() == 0) chk({tag, "_deq_data"}, deq_data, ref_ext(enq_data, enq_type, enq_offset));
            else chk({tag, "_deq_data"}, deq_data, model_q[0]);
        end
    endtask

    // Advance the model by one clock edge, then move to just after the edge.
    task automatic tick();
        logic enq_f;
        logic deq_f;
        logic was_empty;
        if (reset || flush) begin
            model_q.delete();
        end else begin
            was_empty = (model_q.size() == 0);
            enq_f = enq_val && (model_q.size() < DEPTH);
            deq_f = (was_empty ? enq_val : 1'b1) && deq_rdy;
            if (was_empty) begin
                if (enq_f && !deq_rdy) model_q.push_back(ref_ext(enq_data, enq_type, enq_offset));
            end else begin
                if (deq_f) void'(model_q.pop_front());
                if (enq_f) model_q.push_back(ref_ext(enq_data, enq_type, enq_offset));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic ev, input logic [2:0] ty, input logic [1:0] off,
                        input logic [31:0] d, input logic dr, input logic fl, input string tag);
        drive(ev, ty, off, d, dr, fl);
        #3;
        check_model(tag);
        tick();
    endtask

    initial begin
        logic [2:0]  sw_type [4];
        logic [1:0]  sw_off  [4];
        logic [31:0] sw_exp  [4];
        sw_type = '{3'd2, 3'd3, 3'd4, 3'd0};
        sw_off  = '{2'd0, 2'd2, 2'd3, 2'd1};
        sw_exp  = '{32'h0000_00FE, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_7FFE};

        // Reset state
        reset = 1'b1;
        drive(1'b1, 3'd0, 2'd0, 32'h0, 1'b0, 1'b0);
        #2;
        check_model("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_q.delete();

        // Zero-latency pass-through with lb
        drive(1'b1, 3'd1, 2'd2, 32'h1280_3456, 1'b1, 1'b0);
        #3;
        check_model("pt");
        chk("pt_data_const", deq_data, 32'hFFFF_FF80);
        tick();
        chk("pt_count_after", {30'd0, count}, 32'd0);

        // Extension sweep
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sw_type[i], sw_off[i], 32'h8001_7FFE, 1'b1, 1'b0);
            #3;
            check_model("ext");
            chk("ext_const", deq_data, sw_exp[i]);
            tick();
        end

        // Fill to full, then an ignored 4th enqueue
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 2'd0, 32'hA + 32'(i), 1'b0, 1'b0, "fill");
        drive(1'b1, 3'd0, 2'd0, 32'hD, 1'b0, 1'b0);
        #3;
        check_model("full");
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_rdy", {31'd0, enq_rdy}, 32'd0);
        chk("full_count", {30'd0, count}, 32'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0);
            #3;
            check_model("drain");
            chk("drain_order", deq_data, 32'hA + 32'(i));
            tick();
        end
        chk("drain_count", {30'd0, count}, 32'd0);

        // Wrap with concurrent enq/deq at count 2
        step(1'b1, 3'd0, 2'd0, 32'd100, 1'b0, 1'b0, "wrapfill");
        step(1'b1, 3'd0, 2'd0, 32'd101, 1'b0, 1'b0, "wrapfill");
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 3'd0, 2'd0, 32'(i), 1'b1, 1'b0);
            #3;
            check_model("wrap");
            chk("wrap_count", {30'd0, count}, 32'd2);
            tick();
        end
        step(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0, "wrapdrain");
        step(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0, "wrapdrain");

        // Flush with a simultaneous enqueue
        step(1'b1, 3'd0, 2'd0, 32'h11, 1'b0, 1'b0, "flfill");
        step(1'b1, 3'd0, 2'd0, 32'h22, 1'b0, 1'b0, "flfill");
        drive(1'b1, 3'd0, 2'd0, 32'h55, 1'b1, 1'b1);
        #3;
        check_model("flush");
        chk("flush_deq_val", {31'd0, deq_val}, 32'd0);
        tick();
        drive(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0);
        #3;
        chk("flush_count", {30'd0, count}, 32'd0);
        chk("flush_idle_val", {31'd0, deq_val}, 32'd0);
        tick();
        drive(1'b1, 3'd0, 2'd0, 32'h66, 1'b1, 1'b0);
        #3;
        check_model("postflush");
        chk("postflush_data", deq_data, 32'h66);
        tick();

        // Asynchronous reset between edges
        step(1'b1, 3'd0, 2'd0, 32'h31, 1'b0, 1'b0, "rstfill");
        step(1'b1, 3'd0, 2'd0, 32'h32, 1'b0, 1'b0, "rstfill");
        drive(1'b0, 3'd0, 2'd0, 32'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", {30'd0, count}, 32'd0);
        chk("arst_deq_val", {31'd0, deq_val}, 32'd0);
        chk("arst_enq_rdy", {31'd0, enq_rdy}, 32'd0);
        model_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_release_rdy", {31'd0, enq_rdy}, 32'd1);
        @(posedge clk);
        #1;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 32'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0, "rand");
        end
        for (int n = 0; n < DEPTH + 1; n++) step(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
